snake_tick_ctrl: RTL and testbench
==================================

SNAKE_TICK_CTRL -- requirements
Module: snake_tick_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 33554432, clk cycles per game step at speed level 0.
REQ-002 SHALL have parameter EAT_PER_LEVEL, default 4, eats per speed-level increment.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port button, input, 3, raw direction buttons (level, already synchronised).
REQ-006 SHALL have port start, input, 1, one-cycle start/restart request.
REQ-007 SHALL have port pause, input, 1, one-cycle pause-toggle request.
REQ-008 SHALL have port collide, input, 1, datapath collision pulse.
REQ-009 SHALL have port eat, input, 1, datapath food-eaten pulse.
REQ-010 SHALL have port step, output, 1, one-cycle advance strobe to the datapath.
REQ-011 SHALL have port clr, output, 1, one-cycle board-clear strobe to the datapath.
REQ-012 SHALL have port dir, output, 2, committed direction, valid whenever step is high.
REQ-013 SHALL have port state, output, 2, FSM state.
REQ-014 SHALL have port score, output, 8, eat count.
REQ-015 SHALL have port speed, output, 2, current speed level.

Function
REQ-016 Direction codes SHALL be 00 right, 01 down, 10 left, 11 up; the opposite of d is d^2'b10.
REQ-017 Button decode SHALL be combinational: button[2]=0 -> left; else button[1:0]=01 -> up; 10 -> down; otherwise right.
REQ-018 Decoded direction SHALL be latched every cycle into pending_dir; at each step, dir SHALL take pending_dir unless it is the opposite of current dir, in which case dir SHALL remain unchanged.
REQ-019 FSM states SHALL be IDLE=00, RUN=01, PAUSE=10, OVER=11.
REQ-020 IDLE: start -> RUN, with clr high for that same cycle and tick counter zeroed; pause ignored.
REQ-021 RUN: tick counter SHALL count 0..(TICK_DIV>>speed)-1; step SHALL be high for exactly the one cycle when counter wraps to 0.
REQ-022 RUN: pause -> PAUSE with the counter frozen; PAUSE: pause -> RUN, resuming from the frozen count; start is ignored in RUN and PAUSE.
REQ-023 collide and eat SHALL be honoured only in RUN, and only in the cycle immediately after step; at any other time they SHALL be ignored.
REQ-024 collide -> OVER; no further step. Simultaneous collide and eat: collide wins, score unchanged.
REQ-025 eat -> score+1, saturating at 255.
REQ-026 OVER: start -> IDLE with clr high that cycle, score, speed and dir reset; pause ignored.
REQ-027 Simultaneous pause and a tick wrap in RUN: step SHALL still be issued, then the FSM enters PAUSE.
REQ-028 step and clr SHALL never be high in the same cycle.

Reset
REQ-029 rst (synchronous, active-high) SHALL force state=IDLE, dir=00, pending_dir=00, score=0, speed=0, step=0, clr=0, and tick counter=0.
REQ-030 rst asserted mid-RUN SHALL abort the game with no step in the reset cycle or the following cycle.

Configuration
REQ-031 With SNAKE_SPEEDUP_EN defined, speed SHALL increment, saturating at 3, each time EAT_PER_LEVEL further eats are counted since the last increment.
REQ-032 Without SNAKE_SPEEDUP_EN, speed SHALL be constant 0 and the eat-per-level counter SHALL not exist.

Structure
REQ-033 Direction codes, state codes, and the opposite-direction function SHALL live in package snake_pkg, shared with the display datapath.
REQ-034 The tick prescaler (count, freeze, wrap strobe, shift-divided terminal count) SHALL be a separate sub-module snake_tick_gen; the FSM, direction latch and scoring SHALL stay in snake_tick_ctrl.

Verification
REQ-035 Bench SHALL use TICK_DIV=16, EAT_PER_LEVEL=4 for all scenarios.
REQ-036 Scenario 1: rst, then start -> clr=1 in the start cycle, state=01, first step 16 cycles later, then every 16 cycles, dir=00.
REQ-037 Scenario 2: dir=00, hold button=3'b000 (left) -> dir stays 00; then button=3'b101 (up) -> dir=11 at the next step.
REQ-038 Scenario 3: eat pulse one cycle after each of 5 steps -> score=5; with SNAKE_SPEEDUP_EN, speed=1 and step period becomes 8; without it, speed=0.
REQ-039 Scenario 4: collide and eat together one cycle after step -> state=11, score unchanged, no further step; then start -> state=00, clr=1, score=0.
REQ-040 Scenario 5: pause at count 5 -> no step for 100 cycles; pause again -> next step arrives exactly 11 cycles later.
REQ-041 Scenario 6: rst in the cycle of a step wrap -> step=0, state=00; eat asserted two cycles after a step -> score unchanged.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake game codes: directions, FSM states, and direction helpers.
// Used by the tick controller and the display datapath.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_R = 2'b00,
        DIR_D = 2'b01,
        DIR_L = 2'b10,
        DIR_U = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [1:0] SPEED_MAX = 2'd3;
    localparam logic [7:0] SCORE_MAX = 8'hFF;

    function automatic dir_t dir_opp(dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    function automatic dir_t btn_decode(logic [2:0] b);
        dir_t d;
        d = DIR_R;
        unique case (1'b1)
            !b[2]:                   d = DIR_L;
            b[2] && b[1:0] == 2'b01: d = DIR_U;
            b[2] && b[1:0] == 2'b10: d = DIR_D;
            default:                 d = DIR_R;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/snake_tick_ctrl_if.sv
// Controller <-> datapath link: advance/clear strobes, direction,
// and the collision / food pulses coming back.
interface snake_tick_ctrl_if;
    import snake_pkg::*;

    logic step;
    logic clr;
    dir_t dir;
    logic collide;
    logic eat;

    modport master (
        output step,
        output clr,
        output dir,
        input  collide,
        input  eat
    );

    modport slave (
        input  step,
        input  clr,
        input  dir,
        output collide,
        output eat
    );

endinterface

// File: rtl/snake_tick_gen.sv
// Game-step prescaler: freezable counter with a speed-shifted
// terminal count and a one-cycle wrap strobe.
module snake_tick_gen #(
    parameter int TICK_DIV = 33554432
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       run,
    input  logic       hold,
    input  logic [1:0] speed,
    output logic       wrap
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [31:0]   term;
    logic [31:0]   cnt_w;
    logic          hit;

    assign term  = 32'(TICK_DIV) >> speed;
    assign cnt_w = 32'(cnt);
    // >= so a speed-up that shrinks the period mid-count still wraps
    assign hit   = cnt_w >= term - 32'd1;
    assign wrap  = run & hit;

    // a wrap coinciding with hold still rolls over so resume starts fresh
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run && (!hold || hit)) begin
            cnt <= hit ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/snake_tick_ctrl.sv
// Snake game controller: FSM, direction latch, scoring, step timing.
// Define SNAKE_SPEEDUP_EN to raise speed every EAT_PER_LEVEL eats.
module snake_tick_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV      = 33554432,
    parameter int EAT_PER_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        button,
    input  logic              start,
    input  logic              pause,
    output logic [1:0]        state,
    output logic [7:0]        score,
    output logic [1:0]        speed,
    snake_tick_ctrl_if.master dp
);

    state_t     st_q, st_n;
    dir_t       dir_q, dir_n, pend_q, dir_cmt;
    logic [7:0] score_q, score_n;
    logic [1:0] spd;
    logic       step_q;
    logic       wrap;
    logic       run;
    logic       clr_c;
    logic       clear_tick;
    logic       hon;

`ifdef SNAKE_SPEEDUP_EN
    localparam int LW = (EAT_PER_LEVEL > 1) ? $clog2(EAT_PER_LEVEL) : 1;
    logic [1:0]    spd_q, spd_n;
    logic [LW-1:0] lvl_q, lvl_n;
    assign spd = spd_q;
`else
    assign spd = 2'd0;
`endif

    assign run = (st_q == ST_RUN);
    assign hon = step_q;

    snake_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(clear_tick),
        .run  (run),
        .hold (pause),
        .speed(spd),
        .wrap (wrap)
    );

    // reversing onto the body is refused; keep heading instead
    assign dir_cmt = (pend_q == dir_opp(dir_q)) ? dir_q : pend_q;

    assign dp.step = wrap & ~rst;
    assign dp.clr  = clr_c & ~rst;
    assign dp.dir  = dp.step ? dir_cmt : dir_q;

    assign state = st_q;
    assign score = score_q;
    assign speed = spd;

    always_comb begin
        st_n       = st_q;
        dir_n      = dir_q;
        score_n    = score_q;
        clr_c      = 1'b0;
        clear_tick = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
        spd_n      = spd_q;
        lvl_n      = lvl_q;
`endif
        unique case (st_q)
            ST_IDLE: begin
                if (start) begin
                    st_n       = ST_RUN;
                    clr_c      = 1'b1;
                    clear_tick = 1'b1;
                end
            end
            ST_RUN: begin
                if (wrap) dir_n = dir_cmt;
                if (hon && dp.collide) begin
                    st_n = ST_OVER;
                end else begin
                    if (pause) st_n = ST_PAUSE;
                    if (hon && dp.eat) begin
                        if (score_q != SCORE_MAX)
                            score_n = score_q + 8'd1;
`ifdef SNAKE_SPEEDUP_EN
                        if (lvl_q == LW'(EAT_PER_LEVEL - 1)) begin
                            lvl_n = '0;
                            if (spd_q != SPEED_MAX)
                                spd_n = spd_q + 2'd1;
                        end else begin
                            lvl_n = lvl_q + 1'b1;
                        end
`endif
                    end
                end
            end
            ST_PAUSE: begin
                if (pause) st_n = ST_RUN;
            end
            ST_OVER: begin
                if (start) begin
                    st_n       = ST_IDLE;
                    clr_c      = 1'b1;
                    clear_tick = 1'b1;
                    score_n    = '0;
                    dir_n      = DIR_R;
`ifdef SNAKE_SPEEDUP_EN
                    spd_n      = '0;
                    lvl_n      = '0;
`endif
                end
            end
            default: st_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            dir_q   <= DIR_R;
            pend_q  <= DIR_R;
            score_q <= '0;
            step_q  <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
            spd_q   <= '0;
            lvl_q   <= '0;
`endif
        end else begin
            st_q    <= st_n;
            dir_q   <= dir_n;
            pend_q  <= btn_decode(button);
            score_q <= score_n;
            step_q  <= dp.step;
`ifdef SNAKE_SPEEDUP_EN
            spd_q   <= spd_n;
            lvl_q   <= lvl_n;
`endif
        end
    end

endmodule

// File: tb/tb_snake_tick_ctrl.sv
// Self-checking bench for snake_tick_ctrl with TICK_DIV=16, EAT_PER_LEVEL=4.
// Expected steps are queued ahead and popped as the DUT strobes step.
module tb_snake_tick_ctrl;

    localparam int TD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic [2:0] button;
    logic [1:0] state;
    logic [7:0] score;
    logic [1:0] speed;

    snake_tick_ctrl_if dp_if ();

    snake_tick_ctrl #(
        .TICK_DIV     (16),
        .EAT_PER_LEVEL(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .start (start),
        .pause (pause),
        .state (state),
        .score (score),
        .speed (speed),
        .dp    (dp_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [1:0] d;
    } exp_t;

    typedef struct {
        logic [2:0] b;
        logic [1:0] d;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[9];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nxt, mscore, mspd, meats, c0, s0, r, t;

    logic       s_step, s_clr;
    logic [1:0] s_dir, s_state, s_speed;
    logic [7:0] s_score;

    task automatic chk(string nm, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(int c, logic [1:0] d);
        exp_t e;
        e.c = c;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_step  = dp_if.step;
        s_clr   = dp_if.clr;
        s_dir   = dp_if.dir;
        s_state = state;
        s_score = score;
        s_speed = speed;
        if (s_step || s_clr)
            chk("step_clr_excl", int'(s_step & s_clr), 0);
        if (s_step) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_step", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                chk("step_cycle", cyc, e.c);
                chk("step_dir", int'(s_dir), int'(e.d));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(int tgt);
        while (cyc <= tgt) tick();
    endtask

    task automatic drain(string nm);
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic new_game();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b1;
        tick();
        chk("start_clr", int'(s_clr), 1);
        start  = 1'b0;
        c0     = cyc - 1;
        nxt    = c0 + TD;
        mscore = 0;
        mspd   = 0;
        meats  = 0;
    endtask

    task automatic eat_steps(int n, logic [1:0] d);
        for (int k = 0; k < n; k++) begin
            push(nxt, d);
            run_to(nxt);
            dp_if.eat = 1'b1;
            tick();
            dp_if.eat = 1'b0;
            if (mscore < 255) mscore++;
`ifdef SNAKE_SPEEDUP_EN
            meats++;
            if (meats == 4) begin
                meats = 0;
                if (mspd < 3) mspd++;
            end
`endif
            nxt += TD >> mspd;
        end
    endtask

    initial begin
        vecs[0] = '{3'b000, 2'b00};
        vecs[1] = '{3'b101, 2'b11};
        vecs[2] = '{3'b110, 2'b11};
        vecs[3] = '{3'b000, 2'b10};
        vecs[4] = '{3'b100, 2'b10};
        vecs[5] = '{3'b110, 2'b01};
        vecs[6] = '{3'b111, 2'b00};
        vecs[7] = '{3'b011, 2'b00};
        vecs[8] = '{3'b101, 2'b11};

        rst           = 1'b1;
        start         = 1'b0;
        pause         = 1'b0;
        button        = 3'b100;
        dp_if.collide = 1'b0;
        dp_if.eat     = 1'b0;

        tick();
        tick();
        chk("rst_state", int'(s_state), 0);
        chk("rst_score", int'(s_score), 0);
        chk("rst_speed", int'(s_speed), 0);
        chk("rst_step", int'(s_step), 0);
        chk("rst_clr", int'(s_clr), 0);
        chk("rst_dir", int'(s_dir), 0);
        rst = 1'b0;
        tick();

        pause = 1'b1;
        tick();
        pause = 1'b0;
        tick();
        chk("idle_pause", int'(s_state), 0);

        // scenario 1 + direction table
        start = 1'b1;
        tick();
        chk("s1_clr", int'(s_clr), 1);
        chk("s1_state_start", int'(s_state), 0);
        c0    = cyc - 1;
        start = 1'b0;
        tick();
        chk("s1_state_run", int'(s_state), 1);
        chk("s1_clr_off", int'(s_clr), 0);
        for (int i = 0; i < 9; i++) begin
            button = vecs[i].b;
            push(c0 + TD * (i + 1), vecs[i].d);
            run_to(c0 + TD * (i + 1));
            tick();
            chk("dir_vec", int'(s_dir), int'(vecs[i].d));
        end
        drain("s1_missing_steps");

        // scenario 3: eats, speed-up, saturation
        button = 3'b101;
        new_game();
        eat_steps(5, 2'b11);
        push(nxt, 2'b11);
        tick();
        chk("s3_score5", int'(s_score), 5);
`ifdef SNAKE_SPEEDUP_EN
        chk("s3_speed", int'(s_speed), 1);
`else
        chk("s3_speed", int'(s_speed), 0);
`endif
        run_to(nxt);
        drain("s3_period");
        nxt += TD >> mspd;
        eat_steps(255, 2'b11);
        push(nxt, 2'b11);
        tick();
        chk("s3_score_sat", int'(s_score), 255);
        chk("s3_speed_sat", int'(s_speed), mspd);
        run_to(nxt);
        nxt += TD >> mspd;

        // scenario 4: collide+eat together, then restart
        push(nxt, 2'b11);
        run_to(nxt);
        dp_if.collide = 1'b1;
        dp_if.eat     = 1'b1;
        tick();
        dp_if.collide = 1'b0;
        dp_if.eat     = 1'b0;
        tick();
        chk("s4_over", int'(s_state), 3);
        chk("s4_score_kept", int'(s_score), mscore);
        repeat (40) tick();
        drain("s4_no_step");
        pause = 1'b1;
        tick();
        pause = 1'b0;
        tick();
        chk("s4_over_pause", int'(s_state), 3);
        start = 1'b1;
        tick();
        chk("s4_clr", int'(s_clr), 1);
        start = 1'b0;
        tick();
        chk("s4_idle", int'(s_state), 0);
        chk("s4_score0", int'(s_score), 0);
        chk("s4_speed0", int'(s_speed), 0);
        chk("s4_dir0", int'(s_dir), 0);
        repeat (40) tick();

        // scenario 5: pause at count 5, resume, pause on wrap
        button = 3'b111;
        new_game();
        push(nxt, 2'b00);
        run_to(nxt);
        s0 = nxt;
        run_to(s0 + 5);
        pause = 1'b1;
        tick();
        pause = 1'b0;
        tick();
        chk("s5_paused", int'(s_state), 2);
        repeat (50) tick();
        start = 1'b1;
        tick();
        chk("s5_start_ign_clr", int'(s_clr), 0);
        start = 1'b0;
        repeat (50) tick();
        chk("s5_still_paused", int'(s_state), 2);
        pause = 1'b1;
        tick();
        r     = cyc - 1;
        pause = 1'b0;
        push(r + 11, 2'b00);
        run_to(r + 11);
        drain("s5_resume_step");
        t = r + 11 + TD;
        push(t, 2'b00);
        run_to(t - 1);
        pause = 1'b1;
        tick();
        pause = 1'b0;
        tick();
        chk("s5_wrap_pause", int'(s_state), 2);
        drain("s5_wrap_step");
        repeat (10) tick();
        pause = 1'b1;
        tick();
        r     = cyc - 1;
        pause = 1'b0;
        push(r + TD, 2'b00);
        run_to(r + TD);
        drain("s5_after_wrap_pause");

        // scenario 6: reset on a wrap, late eat/collide ignored
        new_game();
        push(nxt, 2'b00);
        run_to(nxt);
        run_to(nxt + TD - 1);
        rst = 1'b1;
        tick();
        chk("s6_rst_step", int'(s_step), 0);
        chk("s6_rst_clr", int'(s_clr), 0);
        rst = 1'b0;
        tick();
        chk("s6_idle", int'(s_state), 0);
        chk("s6_post_step", int'(s_step), 0);
        repeat (30) tick();
        new_game();
        push(nxt, 2'b00);
        run_to(nxt);
        tick();
        dp_if.eat     = 1'b1;
        dp_if.collide = 1'b1;
        tick();
        dp_if.eat     = 1'b0;
        dp_if.collide = 1'b0;
        tick();
        chk("s6_late_eat", int'(s_score), 0);
        chk("s6_late_collide", int'(s_state), 1);
        drain("s6_missing_steps");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
